// File: rtl/tc_local_time_counter.sv
// Free-running TAI time-of-day counter (seconds + nanoseconds). It supports an absolute set, a signed
// offset step and a +/-1 ns drift trim applied every N cycles.
module tc_local_time_counter #(
  parameter int unsigned ClockPeriod_Gen = 20
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic        Enable_EnaIn,
  input  logic [31:0] TimeSet_Second_DatIn,
  input  logic [31:0] TimeSet_Nanosecond_DatIn,
  input  logic        TimeSet_ValIn,
  input  logic [31:0] Offset_Nanosecond_DatIn,
  input  logic        Offset_Sign_DatIn,
  input  logic        Offset_ValIn,
  input  logic [31:0] Drift_Interval_DatIn,
  input  logic        Drift_Sign_DatIn,
  input  logic        Drift_ValIn,
  output logic [31:0] ClockTime_Second_DatOut,
  output logic [31:0] ClockTime_Nanosecond_DatOut,
  output logic        ClockTime_TimeJump_DatOut,
  output logic        ClockTime_ValOut,
  output logic        Error_EvtOut
);

  localparam logic signed [32:0] NsPerSec = 33'sd1000000000;
  localparam logic signed [32:0] PeriodNs = 33'(ClockPeriod_Gen);

  // Request strobes are single-cycle and always accepted or rejected in the cycle they are seen;
  // there is no back-pressure.
  logic [31:0] secReg;
  logic [31:0] nsReg;
  logic        jumpReg;
  logic        validReg;
  logic        errReg;
  logic        seenReg;
  logic [31:0] driftInterval;
  logic        driftSign;
  logic [31:0] driftCnt;

  logic               setOk;
  logic               offRangeOk;
  logic               offOk;
  logic               errNext;
  logic               driftHit;
  logic signed [32:0] driftAdj;
  logic signed [32:0] offAdj;
  logic signed [32:0] periodAdj;
  logic signed [32:0] nsSum;
  logic signed [32:0] nsWrapped;
  logic [31:0]        secNext;

  always_comb begin
    setOk      = TimeSet_ValIn && (TimeSet_Nanosecond_DatIn < 32'd1000000000);
    offRangeOk = Offset_Nanosecond_DatIn < 32'd1000000000;
    // A TimeSet strobe, valid or not, claims the cycle; a coincident offset is dropped.
    offOk      = Offset_ValIn && !TimeSet_ValIn && offRangeOk;
    errNext    = (TimeSet_ValIn && !setOk) || (Offset_ValIn && (TimeSet_ValIn || !offRangeOk));

    driftHit  = Enable_EnaIn && (driftInterval != 32'd0) && (driftCnt == driftInterval - 32'd1);
    driftAdj  = 33'sd0;
    if (driftHit) driftAdj = driftSign ? -33'sd1 : 33'sd1;

    offAdj = $signed({1'b0, Offset_Nanosecond_DatIn});
    if (Offset_Sign_DatIn) offAdj = -offAdj;

    periodAdj = Enable_EnaIn ? PeriodNs : 33'sd0;
    nsSum     = $signed({1'b0, nsReg}) + periodAdj + (offOk ? offAdj : driftAdj);

    nsWrapped = nsSum;
    secNext   = secReg;
    if (nsSum >= NsPerSec) begin
      nsWrapped = nsSum - NsPerSec;
      secNext   = secReg + 32'd1;
    end else if (nsSum < 33'sd0) begin
      nsWrapped = nsSum + NsPerSec;
      secNext   = secReg - 32'd1;
    end
  end

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      secReg        <= '0;
      nsReg         <= '0;
      jumpReg       <= 1'b0;
      validReg      <= 1'b0;
      errReg        <= 1'b0;
      seenReg       <= 1'b0;
      driftInterval <= '0;
      driftSign     <= 1'b0;
      driftCnt      <= '0;
    end else begin
      if (setOk) begin
        secReg <= TimeSet_Second_DatIn;
        nsReg  <= TimeSet_Nanosecond_DatIn;
      end else begin
        secReg <= secNext;
        nsReg  <= nsWrapped[31:0];
      end
      jumpReg  <= setOk || offOk;
      errReg   <= errNext;
      seenReg  <= seenReg || setOk;
      validReg <= Enable_EnaIn && (seenReg || setOk);

      // The drift counter keeps running through offset cycles even though d is not applied there.
      if (Drift_ValIn) begin
        driftInterval <= Drift_Interval_DatIn;
        driftSign     <= Drift_Sign_DatIn;
        driftCnt      <= '0;
      end else if (Enable_EnaIn && driftInterval != 32'd0) begin
        driftCnt <= driftHit ? 32'd0 : driftCnt + 32'd1;
      end
    end
  end

  assign ClockTime_Second_DatOut     = secReg;
  assign ClockTime_Nanosecond_DatOut = nsReg;
  assign ClockTime_TimeJump_DatOut   = jumpReg;
  assign ClockTime_ValOut            = validReg;
  assign Error_EvtOut                = errReg;

endmodule

// File: tb/tb_tc_local_time_counter.sv
// Directed, table-driven bench for tc_local_time_counter with the default 20 ns clock period.
module tb_tc_local_time_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] setSec, setNs;
  logic        setVal;
  logic [31:0] offNs;
  logic        offSign, offVal;
  logic [31:0] driftInt;
  logic        driftSign, driftVal;
  logic [31:0] outSec, outNs;
  logic        outJump, outValid, outErr;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        rst, en;
    logic        setV;
    logic [31:0] setS, setN;
    logic        offV, offSg;
    logic [31:0] offN;
    logic        drV;
    logic [31:0] drI;
    logic        drS;
    logic [31:0] eSec, eNs;
    logic        eJump, eValid, eErr;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  tc_local_time_counter #(.ClockPeriod_Gen(20)) dut (
    .SysClk_ClkIn(clk),
    .SysRst_RstIn(rst),
    .Enable_EnaIn(enable),
    .TimeSet_Second_DatIn(setSec),
    .TimeSet_Nanosecond_DatIn(setNs),
    .TimeSet_ValIn(setVal),
    .Offset_Nanosecond_DatIn(offNs),
    .Offset_Sign_DatIn(offSign),
    .Offset_ValIn(offVal),
    .Drift_Interval_DatIn(driftInt),
    .Drift_Sign_DatIn(driftSign),
    .Drift_ValIn(driftVal),
    .ClockTime_Second_DatOut(outSec),
    .ClockTime_Nanosecond_DatOut(outNs),
    .ClockTime_TimeJump_DatOut(outJump),
    .ClockTime_ValOut(outValid),
    .Error_EvtOut(outErr)
  );

  function automatic vec_t mk(logic r, logic en, logic sv, logic [31:0] ss, logic [31:0] sn,
                              logic ov, logic osg, logic [31:0] on, logic dv, logic [31:0] di,
                              logic ds, logic [31:0] es, logic [31:0] en_ns, logic ej,
                              logic ev, logic ee);
    vec_t v;
    v.rst = r; v.en = en; v.setV = sv; v.setS = ss; v.setN = sn;
    v.offV = ov; v.offSg = osg; v.offN = on; v.drV = dv; v.drI = di; v.drS = ds;
    v.eSec = es; v.eNs = en_ns; v.eJump = ej; v.eValid = ev; v.eErr = ee;
    return v;
  endfunction

  // Plain running step with no strobes: only the expected time changes.
  function automatic vec_t run(logic [31:0] es, logic [31:0] ens);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, ens, 0, 1, 0);
  endfunction

  // Drive one cycle's inputs at the falling edge, then check the registered result after the rising edge.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; enable = v.en;
    setVal = v.setV; setSec = v.setS; setNs = v.setN;
    offVal = v.offV; offSign = v.offSg; offNs = v.offN;
    driftVal = v.drV; driftInt = v.drI; driftSign = v.drS;
    @(posedge clk);
    #1;
    checks++;
    if (outSec === v.eSec && outNs === v.eNs && outJump === v.eJump &&
        outValid === v.eValid && outErr === v.eErr) begin
      passes++;
    end else begin
      $display("FAIL %s: got sec=%0h ns=%0d jump=%0b valid=%0b err=%0b, want sec=%0h ns=%0d jump=%0b valid=%0b err=%0b",
               name, outSec, outNs, outJump, outValid, outErr,
               v.eSec, v.eNs, v.eJump, v.eValid, v.eErr);
    end
  endtask

  initial begin
    int expNs[8];
    rst = 1; enable = 1; setVal = 0; setSec = 0; setNs = 0;
    offVal = 0; offSign = 0; offNs = 0; driftVal = 0; driftInt = 0; driftSign = 0;

    //          rst en sv setS         setN          ov osg offN         dv di ds  eSec         eNs          J V E
    tbl.push_back(mk(1, 1, 0, 0,            0,            0, 0, 0,            0, 0, 0, 0,            0,           0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0,            0, 0, 0,            0, 0, 0, 0,            20,          0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 5,            999_999_960,  0, 0, 0,            0, 0, 0, 5,            999_999_960, 1, 1, 0));
    tbl.push_back(run(5, 999_999_980));
    tbl.push_back(run(6, 0));
    tbl.push_back(mk(0, 1, 1, 7,            10,           0, 0, 0,            0, 0, 0, 7,            10,          1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0,            1, 1, 40,           0, 0, 0, 6,            999_999_990, 1, 1, 0));
    tbl.push_back(run(7, 10));
    tbl.push_back(mk(0, 1, 0, 0,            0,            1, 0, 999_999_990,  0, 0, 0, 8,            20,          1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0,            1, 0, 1_000_000_000,0, 0, 0, 8,            40,          0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 3,            1_000_000_000,0, 0, 0,            0, 0, 0, 8,            60,          0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 9,            100,          1, 1, 5,            0, 0, 0, 9,            100,         1, 1, 1));
    tbl.push_back(run(9, 120));
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFF,999_999_980,  0, 0, 0,            0, 0, 0, 32'hFFFF_FFFF,999_999_980, 1, 1, 0));
    tbl.push_back(run(0, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0,            1, 1, 40,           0, 0, 0, 32'hFFFF_FFFF,999_999_980, 1, 1, 0));
    tbl.push_back(run(0, 0));
    tbl.push_back(mk(1, 1, 0, 0,            0,            1, 1, 40,           0, 0, 0, 0,            0,           0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,            0,            0, 0, 0,            0, 0, 0, 0,            20,          0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1,            500,          0, 0, 0,            0, 0, 0, 1,            500,         1, 1, 0));
    tbl.push_back(run(1, 520));
    tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0, 1,            520,         0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,            0, 0, 0,            0, 0, 0, 1,            520,         0, 0, 0));
    tbl.push_back(run(1, 540));
    tbl.push_back(mk(0, 0, 1, 2,            0,            0, 0, 0,            0, 0, 0, 2,            0,           1, 0, 0));
    tbl.push_back(run(2, 20));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Drift +1 every 4th step, starting from a set to 10 s / 0 ns.
    step(mk(0, 1, 1, 10, 0, 0, 0, 0, 1, 4, 0, 10, 0, 1, 1, 0), "drift_pos_set");
    expNs = '{20, 40, 60, 81, 101, 121, 141, 162};
    for (int i = 0; i < 8; i++) step(run(10, expNs[i]), $sformatf("drift_pos%0d", i));

    // Drift -1 every 4th step.
    step(mk(0, 1, 1, 10, 0, 0, 0, 0, 1, 4, 1, 10, 0, 1, 1, 0), "drift_neg_set");
    expNs = '{20, 40, 60, 79, 99, 119, 139, 158};
    for (int i = 0; i < 8; i++) step(run(10, expNs[i]), $sformatf("drift_neg%0d", i));

    // Offset landing on the drift cycle suppresses d but the counter still restarts.
    step(mk(0, 1, 1, 10, 0, 0, 0, 0, 1, 4, 0, 10, 0, 1, 1, 0), "drift_off_set");
    step(run(10, 20), "drift_off0");
    step(run(10, 40), "drift_off1");
    step(run(10, 60), "drift_off2");
    step(mk(0, 1, 0, 0, 0, 1, 0, 100, 0, 0, 0, 10, 180, 1, 1, 0), "drift_off3");
    expNs = '{200, 220, 240, 261, 281, 301, 321, 342};
    for (int i = 0; i < 8; i++) step(run(10, expNs[i]), $sformatf("drift_off_after%0d", i));

    // Interval 0 turns the trim off.
    step(mk(0, 1, 1, 10, 0, 0, 0, 0, 1, 0, 0, 10, 0, 1, 1, 0), "drift_off_cfg");
    for (int i = 0; i < 5; i++) step(run(10, 20 * (i + 1)), $sformatf("drift_none%0d", i));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
